// File: rtl/rr_dispatcher_pkg.sv
// Shared types and helpers for the 1:N round-robin dispatcher.
// Optional per-port statistics are enabled with RR_DISPATCHER_STAT_EN.
package rr_dispatcher_pkg;

    localparam int DEF_PORT = 4;
    localparam int DEF_IDX  = $clog2(DEF_PORT);
    localparam int DEF_CNT  = 16;

    typedef logic [DEF_IDX-1:0] ptr_t;
    typedef logic [DEF_CNT-1:0] cnt_t;

    // Rotation wraps at the real port count, not at the next power of two.
    function automatic int next_ptr(input int sel, input int port);
        return (sel == port - 1) ? 0 : sel + 1;
    endfunction

endpackage

// File: rtl/rr_dispatch_slot.sv
// One-entry output slot: holds a beat until its consumer takes it.
// With RR_DISPATCHER_STAT_EN defined it also counts beats loaded into it.
module rr_dispatch_slot
    import rr_dispatcher_pkg::*;
#(
    parameter int DATA = 32
`ifdef RR_DISPATCHER_STAT_EN
    , parameter int CNT = DEF_CNT
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            ready,
    input  logic [DATA-1:0] in_data,
`ifdef RR_DISPATCHER_STAT_EN
    output logic [CNT-1:0]  cnt,
`endif
    output logic            valid,
    output logic [DATA-1:0] data
);

    // A load wins over a drain so a slot can hand off and refill in one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

`ifdef RR_DISPATCHER_STAT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/rr_dispatcher.sv
// 1:N round-robin dispatcher: each accepted beat goes to the next free slot.
// Define RR_DISPATCHER_STAT_EN to add the per-port dsp_cnt counters.
module rr_dispatcher
    import rr_dispatcher_pkg::*;
#(
    parameter int PORT = DEF_PORT,
    parameter int DATA = 32,
    parameter int CNT  = DEF_CNT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 in_valid,
    input  logic [DATA-1:0]      in_data,
    output logic                 in_ready,
    output logic [PORT-1:0]      out_valid,
    output logic [PORT*DATA-1:0] out_data,
`ifdef RR_DISPATCHER_STAT_EN
    output logic [PORT*CNT-1:0]  dsp_cnt,
`endif
    input  logic [PORT-1:0]      out_ready
);

    localparam int IDX = $clog2(PORT);
    typedef logic [IDX-1:0] idx_t;
    typedef logic [CNT-1:0] dsp_cnt_t;

    idx_t            r_ptr;
    idx_t            sel;
    idx_t            cand;
    logic            any_free;
    logic            xfer;
    logic [PORT-1:0] free;
    logic [PORT-1:0] load;

    assign free     = ~out_valid | out_ready;
    assign in_ready = reset_n && !stall && any_free;
    assign xfer     = in_valid && in_ready;

    // Walk the ports starting at r_ptr; the first free one takes the beat.
    always_comb begin
        sel      = '0;
        any_free = 1'b0;
        cand     = r_ptr;
        for (int i = 0; i < PORT; i++) begin
            if (!any_free && free[cand]) begin
                sel      = cand;
                any_free = 1'b1;
            end
            cand = idx_t'(next_ptr(int'(cand), PORT));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (xfer) begin
            r_ptr <= idx_t'(next_ptr(int'(sel), PORT));
        end
    end

    for (genvar p = 0; p < PORT; p++) begin : g_slot
        assign load[p] = xfer && (sel == idx_t'(p));

`ifdef RR_DISPATCHER_STAT_EN
        dsp_cnt_t slot_cnt;
        assign dsp_cnt[p*CNT +: CNT] = slot_cnt;
`endif

        rr_dispatch_slot #(
            .DATA(DATA)
`ifdef RR_DISPATCHER_STAT_EN
            , .CNT(CNT)
`endif
        ) u_slot (
            .clk(clk),
            .reset_n(reset_n),
            .load(load[p]),
            .ready(out_ready[p]),
            .in_data(in_data),
`ifdef RR_DISPATCHER_STAT_EN
            .cnt(slot_cnt),
`endif
            .valid(out_valid[p]),
            .data(out_data[p*DATA +: DATA])
        );
    end

endmodule

// File: tb/tb_rr_dispatcher.sv
// Directed bench for rr_dispatcher: a 4-port and a 3-port instance share one clock.
// Counter checks are compiled in when RR_DISPATCHER_STAT_EN is defined.
module tb_rr_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;

    logic         stall4, in_valid4, in_ready4;
    logic [31:0]  in_data4;
    logic [3:0]   out_valid4, out_ready4;
    logic [127:0] out_data4;

    logic         stall3, in_valid3, in_ready3;
    logic [31:0]  in_data3;
    logic [2:0]   out_valid3, out_ready3;
    logic [95:0]  out_data3;

`ifdef RR_DISPATCHER_STAT_EN
    logic [63:0]  dsp_cnt4;
    logic [47:0]  dsp_cnt3;
`endif

    rr_dispatcher #(.PORT(4), .DATA(32), .CNT(16)) u4 (
        .clk(clk),
        .reset_n(reset_n),
        .stall(stall4),
        .in_valid(in_valid4),
        .in_data(in_data4),
        .in_ready(in_ready4),
        .out_valid(out_valid4),
        .out_data(out_data4),
`ifdef RR_DISPATCHER_STAT_EN
        .dsp_cnt(dsp_cnt4),
`endif
        .out_ready(out_ready4)
    );

    rr_dispatcher #(.PORT(3), .DATA(32), .CNT(16)) u3 (
        .clk(clk),
        .reset_n(reset_n),
        .stall(stall3),
        .in_valid(in_valid3),
        .in_data(in_data3),
        .in_ready(in_ready3),
        .out_valid(out_valid3),
        .out_data(out_data3),
`ifdef RR_DISPATCHER_STAT_EN
        .dsp_cnt(dsp_cnt3),
`endif
        .out_ready(out_ready3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] slot4(input int p);
        return out_data4[p*32 +: 32];
    endfunction

    function automatic logic [31:0] slot3(input int p);
        return out_data3[p*32 +: 32];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        stall4     = 1'b0;
        in_valid4  = 1'b0;
        in_data4   = '0;
        out_ready4 = 4'hF;
        stall3     = 1'b0;
        in_valid3  = 1'b0;
        in_data3   = '0;
        out_ready3 = 3'b111;

        // Reset: in_ready held low even though every slot is free.
        #2;
        check("rst_in_ready", 64'(in_ready4), 64'(0));
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid4), 64'(0));
        check("rst_r_ptr", 64'(u4.r_ptr), 64'(0));
        check("rst_out_data", 64'(out_data4[63:0]), 64'(0));
        reset_n = 1'b1;

        // Back-to-back beats rotate 0,1,2,3,0,... with consumers always ready.
        in_valid4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data4 = 32'hA000_0000 + 32'(i);
            #2;
            check("t1_in_ready", 64'(in_ready4), 64'(1));
            tick();
            check("t1_out_valid", 64'(out_valid4), 64'(4'b0001 << (i % 4)));
            check("t1_out_data", 64'(slot4(i % 4)), 64'(32'hA000_0000 + 32'(i)));
        end
        in_valid4 = 1'b0;
        tick();
        check("t1_drained", 64'(out_valid4), 64'(0));
        check("t1_r_ptr", 64'(u4.r_ptr), 64'(0));

        // Three-port rotation wraps from 2 back to 0.
        in_valid3 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data3 = 32'hC300_0000 + 32'(i);
            tick();
            check("t2_out_valid", 64'(out_valid3), 64'(3'b001 << (i % 3)));
            check("t2_out_data", 64'(slot3(i % 3)), 64'(32'hC300_0000 + 32'(i)));
            check("t2_r_ptr", 64'(u3.r_ptr), 64'((i + 1) % 3));
        end
        in_valid3 = 1'b0;

        // Port 1 blocked and full with r_ptr=1: the next beat skips to port 2.
        out_ready4 = 4'b1101;
        in_valid4  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data4 = 32'hB000_0000 + 32'(i);
            tick();
        end
        check("t3_r_ptr_pre", 64'(u4.r_ptr), 64'(1));
        check("t3_port1_full", 64'(out_valid4[1]), 64'(1));
        in_data4 = 32'hAAAA_0001;
        #2;
        check("t3_in_ready", 64'(in_ready4), 64'(1));
        tick();
        check("t3_port2_data", 64'(slot4(2)), 64'(32'hAAAA_0001));
        check("t3_out_valid", 64'(out_valid4), 64'(4'b0110));
        check("t3_r_ptr", 64'(u4.r_ptr), 64'(3));
        check("t3_port1_hold", 64'(slot4(1)), 64'(32'hB000_0001));

        // Fill every slot, then free only port 2.
        out_ready4 = 4'b0000;
        in_data4   = 32'hCCCC_0000;
        tick();
        in_data4   = 32'hDDDD_0000;
        tick();
        in_data4   = 32'hEEEE_0000;
        #2;
        check("t4_full_in_ready", 64'(in_ready4), 64'(0));
        tick();
        check("t4_full_r_ptr", 64'(u4.r_ptr), 64'(1));
        check("t4_full_valid", 64'(out_valid4), 64'(4'hF));
        check("t4_port2_hold", 64'(slot4(2)), 64'(32'hAAAA_0001));
        out_ready4 = 4'b0100;
        #2;
        check("t4_in_ready", 64'(in_ready4), 64'(1));
        tick();
        in_valid4 = 1'b0;
        check("t4_out_valid", 64'(out_valid4), 64'(4'hF));
        check("t4_port2_data", 64'(slot4(2)), 64'(32'hEEEE_0000));
        check("t4_r_ptr", 64'(u4.r_ptr), 64'(3));

        // Stall blocks acceptance and freezes the pointer while slots drain.
        out_ready4 = 4'hF;
        stall4     = 1'b1;
        in_valid4  = 1'b1;
        in_data4   = 32'hF000_0000;
        #2;
        check("t5_in_ready", 64'(in_ready4), 64'(0));
        tick();
        check("t5_drained", 64'(out_valid4), 64'(0));
        tick();
        tick();
        check("t5_r_ptr", 64'(u4.r_ptr), 64'(3));
        check("t5_still_empty", 64'(out_valid4), 64'(0));
        stall4 = 1'b0;
        #2;
        check("t5_resume_ready", 64'(in_ready4), 64'(1));
        tick();
        in_valid4 = 1'b0;
        check("t5_resume_valid", 64'(out_valid4), 64'(4'b1000));
        check("t5_resume_data", 64'(slot4(3)), 64'(32'hF000_0000));
        check("t5_resume_r_ptr", 64'(u4.r_ptr), 64'(0));

        // Reset with two slots full discards them.
        tick();
        out_ready4 = 4'b0000;
        in_valid4  = 1'b1;
        in_data4   = 32'h1111_0000;
        tick();
        in_data4   = 32'h1111_0001;
        tick();
        in_valid4  = 1'b0;
        check("t6_pre_valid", 64'(out_valid4), 64'(4'b0011));
        check("t6_pre_r_ptr", 64'(u4.r_ptr), 64'(2));
        reset_n = 1'b0;
        #2;
        check("t6_rst_in_ready", 64'(in_ready4), 64'(0));
        tick();
        reset_n = 1'b1;
        check("t6_out_valid", 64'(out_valid4), 64'(0));
        check("t6_r_ptr", 64'(u4.r_ptr), 64'(0));
        check("t6_out_data", 64'(out_data4[63:0]), 64'(0));
`ifdef RR_DISPATCHER_STAT_EN
        check("t6_cnt4_clear", dsp_cnt4, 64'(0));
        check("t6_cnt3_clear", 64'(dsp_cnt3), 64'(0));
`endif

        // Only port 0 drains: after the first lap every beat lands on port 0.
        out_ready4 = 4'b0001;
        in_valid4  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data4 = 32'h2222_0000 + 32'(i);
            tick();
        end
        in_valid4 = 1'b0;
        check("t6_lap_valid", 64'(out_valid4), 64'(4'hF));
        check("t6_lap_port0", 64'(slot4(0)), 64'(32'h2222_0007));
        check("t6_lap_port3", 64'(slot4(3)), 64'(32'h2222_0003));
        check("t6_lap_r_ptr", 64'(u4.r_ptr), 64'(1));
`ifdef RR_DISPATCHER_STAT_EN
        check("t6_cnt_port0", 64'(dsp_cnt4[15:0]), 64'(5));
        check("t6_cnt_port1", 64'(dsp_cnt4[31:16]), 64'(1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
